// File: rtl/fas_mw_arbiter.sv
// Two-requester 64-bit add/subtract unit: arbitrates between requesters, then
// runs each operation as two 32-bit passes through one shared FAS_32bit slice.

module FAS_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    input  logic        bcin,
    output logic [31:0] r,
    output logic        cout,
    output logic        bout
);
    logic [32:0] sum_s;
    logic [32:0] dif_s;

    // 33-bit add and subtract; bit 32 is carry-out or borrow-out respectively
    always_comb begin
        sum_s = {1'b0, a} + {1'b0, b} + {32'd0, bcin};
        dif_s = {1'b0, a} - {1'b0, b} - {32'd0, bcin};
        if (sub) begin
            r = dif_s[31:0];
        end else begin
            r = sum_s[31:0];
        end
        cout = sum_s[32];
        bout = dif_s[32];
    end
endmodule

module fas_mw_arbiter #(
    parameter int unsigned RR_EN = 32'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_op,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_op,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
    output logic        rsp_cb,
    output logic        rsp_ovf,
    output logic        rsp_zero,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        op_q, op_d;
    logic        id_q, id_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [31:0] lo_q, lo_d;
    logic        c_q, c_d;
    logic [63:0] result_q, result_d;
    logic        cb_q, cb_d;
    logic        ovf_q, ovf_d;
    logic        zero_q, zero_d;

    logic        grant_s;
    logic        req0_ready_s;
    logic        req1_ready_s;
    logic [31:0] fas_a_s;
    logic [31:0] fas_b_s;
    logic        fas_bcin_s;
    logic [31:0] fas_r_s;
    logic        fas_cout_s;
    logic        fas_bout_s;
    logic        fas_cb_s;
    logic [63:0] full_r_s;

    function automatic logic ovf_calc(input logic sub, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
        if (sub) begin
            return (a_msb != b_msb) && (r_msb != a_msb);
        end else begin
            return (a_msb == b_msb) && (r_msb != a_msb);
        end
    endfunction

    FAS_32bit u_fas (
        .a    (fas_a_s),
        .b    (fas_b_s),
        .sub  (op_q),
        .bcin (fas_bcin_s),
        .r    (fas_r_s),
        .cout (fas_cout_s),
        .bout (fas_bout_s)
    );

    // Next-state, grant and datapath sequencing for the two-word operation
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        op_d         = op_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        lo_d         = lo_q;
        c_d          = c_q;
        result_d     = result_q;
        cb_d         = cb_q;
        ovf_d        = ovf_q;
        zero_d       = zero_q;
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;
        grant_s      = 1'b0;
        fas_cb_s     = op_q ? fas_bout_s : fas_cout_s;
        full_r_s     = {fas_r_s, lo_q};

        // The high pass reuses the slice with the low-word carry/borrow chained in
        if (state_q == HI) begin
            fas_a_s    = a_q[63:32];
            fas_b_s    = b_q[63:32];
            fas_bcin_s = c_q;
        end else begin
            fas_a_s    = a_q[31:0];
            fas_b_s    = b_q[31:0];
            fas_bcin_s = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    if (req0_valid && req1_valid) begin
                        grant_s = (RR_EN != 32'd0) ? ptr_q : 1'b0;
                    end else begin
                        grant_s = req1_valid;
                    end
                    req0_ready_s = ~grant_s;
                    req1_ready_s = grant_s;
                    id_d         = grant_s;
                    op_d         = grant_s ? req1_op : req0_op;
                    a_d          = grant_s ? req1_a  : req0_a;
                    b_d          = grant_s ? req1_b  : req0_b;
                    state_d      = LO;
                end else begin
                    state_d = IDLE;
                end
            end
            LO: begin
                lo_d    = fas_r_s;
                c_d     = fas_cb_s;
                state_d = HI;
            end
            HI: begin
                result_d = full_r_s;
                cb_d     = fas_cb_s;
                ovf_d    = ovf_calc(op_q, a_q[63], b_q[63], fas_r_s[31]);
                zero_d   = (full_r_s == 64'd0);
                state_d  = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    ptr_d   = ~id_q;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            op_q     <= 1'b0;
            id_q     <= 1'b0;
            a_q      <= 64'd0;
            b_q      <= 64'd0;
            lo_q     <= 32'd0;
            c_q      <= 1'b0;
            result_q <= 64'd0;
            cb_q     <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            op_q     <= op_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            lo_q     <= lo_d;
            c_q      <= c_d;
            result_q <= result_d;
            cb_q     <= cb_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign req0_ready = req0_ready_s;
    assign req1_ready = req1_ready_s;
    assign rsp_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_cb     = cb_q;
    assign rsp_ovf    = ovf_q;
    assign rsp_zero   = zero_q;
endmodule

// File: tb/tb_fas_mw_arbiter.sv
// Self-checking bench: directed vector table, arbitration/backpressure/reset
// sequences, and randomized operations against a 65-bit arithmetic model.

module tb_fas_mw_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_op, req1_valid, req1_op, rsp_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cb, rsp_ovf, rsp_zero, busy;
    logic [63:0] rsp_result;
    logic        f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_rsp_cb, f_rsp_ovf, f_rsp_zero, f_busy;
    logic [63:0] f_rsp_result;

    int n_pass = 0;
    int n_total = 0;

    fas_mw_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_cb(rsp_cb), .rsp_ovf(rsp_ovf),
        .rsp_zero(rsp_zero), .busy(busy)
    );

    fas_mw_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id),
        .rsp_result(f_rsp_result), .rsp_cb(f_rsp_cb), .rsp_ovf(f_rsp_ovf),
        .rsp_zero(f_rsp_zero), .busy(f_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        id;
        logic        op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        logic        cb;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact 65-bit unsigned and signed arithmetic
    task automatic model(input logic op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic cb, output logic ovf, output logic zero);
        logic [64:0]        w;
        logic signed [64:0] s;
        if (op) begin
            w = {1'b0, a} - {1'b0, b};
            s = $signed({a[63], a}) - $signed({b[63], b});
        end else begin
            w = {1'b0, a} + {1'b0, b};
            s = $signed({a[63], a}) + $signed({b[63], b});
        end
        r    = w[63:0];
        cb   = w[64];
        ovf  = (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -65'sh0_8000_0000_0000_0000);
        zero = (r == 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("reset_ready0", {63'd0, req0_ready}, 64'd0);
        chk("reset_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        tick();
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_result", rsp_result, 64'd0);
        chk("reset_flags", {60'd0, rsp_id, rsp_cb, rsp_ovf, rsp_zero}, 64'd0);
        chk("reset_ready_both", {62'd0, req0_ready, req1_ready}, 64'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    // One complete operation from an idle DUT; stall = cycles rsp_ready stays low in DONE
    task automatic run_txn(input logic id, input logic op, input logic [63:0] a, input logic [63:0] b,
                           input int stall, output logic [63:0] r, output logic cb,
                           output logic ovf, output logic zero, output logic rid, output int lat);
        logic [3:0] flags;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req0_valid = 1'b0;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req1_valid = 1'b0;
        end
        rsp_ready = (stall == 0);
        #1;
        chk("grant", {62'd0, req1_ready, req0_ready}, id ? 64'd2 : 64'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
        req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
        req0_op = ~op; req1_op = ~op;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        r = rsp_result; cb = rsp_cb; ovf = rsp_ovf; zero = rsp_zero; rid = rsp_id;
        flags = {rid, cb, ovf, zero};
        for (int i = 0; i < stall; i++) begin
            tick();
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            #1;
            chk("stall_valid", {63'd0, rsp_valid}, 64'd1);
            chk("stall_result", rsp_result, r);
            chk("stall_flags", {60'd0, rsp_id, rsp_cb, rsp_ovf, rsp_zero}, {60'd0, flags});
            chk("stall_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("post_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("post_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] r, er;
        logic        cb, ovf, zero, rid, ecb, eovf, ezero;
        int          lat;
        int          ng, ng_f;
        logic        g[4];
        logic        g_f[4];
        int          cyc[4];
        logic        rid_;
        logic        op_;
        logic [63:0] a_, b_;

        vecs[0] = '{1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 64'h5, 64'h5, 64'h0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 64'h0000_0001_0000_0000, 64'h1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0};

        req0_op = 1'b0; req1_op = 1'b0;
        req0_a = 64'd0; req0_b = 64'd0; req1_a = 64'd0; req1_b = 64'd0;
        do_reset();

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, 0, r, cb, ovf, zero, rid, lat);
            chk("vec_latency", 64'(lat), 64'd3);
            chk("vec_result", r, vecs[i].r);
            chk("vec_cb", {63'd0, cb}, {63'd0, vecs[i].cb});
            chk("vec_ovf", {63'd0, ovf}, {63'd0, vecs[i].ovf});
            chk("vec_zero", {63'd0, zero}, {63'd0, vecs[i].zero});
            chk("vec_id", {63'd0, rid}, {63'd0, vecs[i].id});
        end

        // Backpressure: five stalled cycles in DONE
        run_txn(1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5, r, cb, ovf, zero, rid, lat);
        chk("bp_result", r, 64'h2222_2222_2222_2211);
        chk("bp_id", {63'd0, rid}, 64'd1);

        // Arbitration: both held valid for four transactions on both variants
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        ng = 0; ng_f = 0;
        for (int c = 0; c < 40 && (ng < 4 || ng_f < 4); c++) begin
            if ((req0_ready || req1_ready) && ng < 4) begin
                chk("rr_onehot", {62'd0, req0_ready, req1_ready}, req1_ready ? 64'd1 : 64'd2);
                g[ng] = req1_ready; cyc[ng] = c; ng++;
            end
            if ((f_req0_ready || f_req1_ready) && ng_f < 4) begin
                g_f[ng_f] = f_req1_ready; ng_f++;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_count", 64'(ng), 64'd4);
        chk("fp_count", 64'(ng_f), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", {63'd0, g[i]}, (i % 2 == 1) ? 64'd1 : 64'd0);
            chk("fp_order", {63'd0, g_f[i]}, 64'd0);
        end
        for (int i = 1; i < 4; i++) chk("rr_spacing", 64'(cyc[i] - cyc[i-1]), 64'd4);
        for (int i = 0; i < 5; i++) tick();

        // Reset during HI with pointer at 1 abandons the operation
        do_reset();
        run_txn(1'b0, 1'b0, 64'd1, 64'd2, 0, r, cb, ovf, zero, rid, lat);
        req1_valid = 1'b1; req1_op = 1'b0; req1_a = 64'd7; req1_b = 64'd8;
        #1;
        chk("hi_grant", {62'd0, req1_ready, req0_ready}, 64'd2);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("hi_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("hi_rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("hi_rst_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hi_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("hi_ptr_reset", {62'd0, req1_ready, req0_ready}, 64'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        run_txn(1'b0, 1'b1, 64'd10, 64'd3, 0, r, cb, ovf, zero, rid, lat);
        chk("hi_after_result", r, 64'd7);
        chk("hi_after_latency", 64'(lat), 64'd3);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rid_ = 1'($urandom_range(0, 1));
            op_  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: a_ = 64'h7FFF_FFFF_FFFF_FFFF;
                1: a_ = 64'h8000_0000_0000_0000;
                2: a_ = 64'h0000_0000_FFFF_FFFF;
                default: a_ = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 4))
                0: b_ = 64'd1;
                1: b_ = a_;
                2: b_ = 64'hFFFF_FFFF_FFFF_FFFF;
                default: b_ = {$urandom, $urandom};
            endcase
            model(op_, a_, b_, er, ecb, eovf, ezero);
            run_txn(rid_, op_, a_, b_, int'($urandom_range(0, 2)), r, cb, ovf, zero, rid, lat);
            chk("rnd_latency", 64'(lat), 64'd3);
            chk("rnd_result", r, er);
            chk("rnd_flags", {60'd0, rid, cb, ovf, zero}, {60'd0, rid_, ecb, eovf, ezero});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fas_mw_arbiter.md
FAS_MW_ARBITER -- requirements
Module: fas_mw_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, SHALL select arbitration: 1 = round-robin, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1 each  SHALL indicate requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  SHALL be the grant; an operation is accepted when valid and ready are both high.
REQ-006 req0_op / req1_op  input  1 each  SHALL select the operation: 0 = add, 1 = subtract.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  64 each  SHALL carry the operands.
REQ-008 rsp_valid  output  1  SHALL flag a valid result.
REQ-009 rsp_ready  input  1  SHALL be the consumer accept signal.
REQ-010 rsp_id  output  1  SHALL give the requester index of the result.
REQ-011 rsp_result  output  64  SHALL carry a+b or a-b, modulo 2^64.
REQ-012 rsp_cb  output  1  SHALL carry the carry-out (add) or borrow-out (subtract) of bit 63.
REQ-013 rsp_ovf / rsp_zero  output  1 each  SHALL carry the signed-overflow and result-equals-zero flags.
REQ-014 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-015 Exactly one FAS_32bit instance SHALL perform all arithmetic; the block SHALL time-share it across the two words of each operation.
REQ-016 The block SHALL implement states IDLE, LO, HI and DONE.
REQ-017 IDLE: if any req_valid is high, the block SHALL combinationally raise ready for exactly one requester, capture that requester's op/a/b/id, and go to LO; otherwise it SHALL stay in IDLE.
REQ-018 Both requesters valid with RR_EN=1: the block SHALL grant the requester indicated by the priority pointer.
REQ-019 Both requesters valid with RR_EN=0: the block SHALL always grant requester 0.
REQ-020 The priority pointer SHALL move to the non-served requester on each response handshake.
REQ-021 A single valid requester SHALL be granted regardless of the pointer.
REQ-022 Both ready outputs SHALL be 0 in LO, HI and DONE; req_valid changes after acceptance SHALL have no effect.
REQ-023 LO: the block SHALL drive operand bits [31:0] with bcin=0, register the low word and the cout (add) or bout (sub), then go to HI.
REQ-024 HI: the block SHALL drive operand bits [63:32] with bcin equal to the registered low-word carry/borrow, register the high word, rsp_cb, rsp_ovf and rsp_zero, then go to DONE.
REQ-025 Overflow for add SHALL be (a[63]==b[63]) && (r[63]!=a[63]); for subtract (a[63]!=b[63]) && (r[63]!=a[63]).
REQ-026 DONE: rsp_valid SHALL be 1 and all rsp_* outputs SHALL hold stable until rsp_ready=1; the block SHALL then return to IDLE.
REQ-027 Latency: for acceptance in cycle T, rsp_valid SHALL rise in cycle T+3; back-to-back acceptances SHALL be no closer than 4 cycles (rsp_ready held high).
REQ-028 rsp_ready while not in DONE SHALL be ignored.
REQ-029 rsp_* outputs outside DONE are don't-care, except that rsp_valid SHALL be 0.

Reset
REQ-030 While rst_n=0 at a clock edge, the block SHALL enter IDLE and set: pointer=0, rsp_valid=0, busy=0, rsp_result=0, rsp_id=0, rsp_cb=0, rsp_ovf=0, rsp_zero=0.
REQ-031 Both ready outputs SHALL be 0 during reset.
REQ-032 Reset in LO, HI or DONE SHALL abandon the operation and produce no response.

Verification
REQ-033 Cross-word carry: req0 add, a=0x00000000FFFFFFFF, b=0x0000000000000001 -> rsp_valid at T+3, result=0x0000000100000000, cb=0, ovf=0, zero=0, id=0.
REQ-034 Borrow: req1 sub, a=0, b=1 -> result=0xFFFFFFFFFFFFFFFF, cb=1, ovf=0, id=1.
REQ-035 Overflow: add, a=0x7FFFFFFFFFFFFFFF, b=1 -> result=0x8000000000000000, ovf=1, cb=0; add, a=0xFFFFFFFFFFFFFFFF, b=1 -> result=0, cb=1, zero=1, ovf=0.
REQ-036 Arbitration (RR_EN=1): both requesters held valid for 4 transactions -> grant order 0,1,0,1; with RR_EN=0 -> order 0,0,0,0.
REQ-037 Backpressure: rsp_ready low for 5 cycles in DONE -> rsp_* stable and ready outputs 0 throughout; completes when rsp_ready rises.
REQ-038 Reset in HI -> no rsp_valid; next accepted request is served normally from pointer=0.
